// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle execute stage that sits after the 8-bit accumulator
// register file. Ops that finish in one cycle share the same IDLE -> EXEC -> WB
// sequence as the iterative SHL (one bit per cycle) and MUL (shift-add). All
// write-back controls are registered and are valid only during WB.
module alu_exec_unit #(
    parameter int RAW       = 3,
    parameter int MUL_ITERS = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ex_start,
    input  logic [2:0]     ex_op,
    input  logic [RAW-1:0] ex_dst,
    input  logic [7:0]     ex_acc_i,
    input  logic [7:0]     ex_read_i,
    output logic           ex_busy,
    output logic           ex_done,
    output logic           ex_carry,
    output logic           ex_zero,
    output logic [RAW-1:0] rf_write_addr,
    output logic           rf_write_en,
    output logic [7:0]     rf_write_val,
    output logic           rf_reset_acc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    // Counter must hold both the MUL iteration count and a 3-bit shift amount.
    localparam int CW = ($clog2(MUL_ITERS + 1) > 3) ? $clog2(MUL_ITERS + 1) : 3;

    logic [1:0]     r_state;
    logic [2:0]     r_op;
    logic [RAW-1:0] r_dst;
    logic [7:0]     r_a;
    logic [7:0]     r_b;
    logic [CW-1:0]  r_cnt;
    logic [15:0]    r_prod;
    logic [15:0]    r_mcand;
    logic [7:0]     r_mplier;

    logic           r_done;
    logic           r_carry;
    logic           r_zero;
    logic [RAW-1:0] r_waddr;
    logic           r_wen;
    logic [7:0]     r_wval;
    logic           r_rst_acc;

    logic [8:0]     w_sum;
    logic [8:0]     w_diff;
    logic [15:0]    w_prod_next;
    logic           w_shl_active;
    logic [7:0]     w_result;
    logic           w_carry;
    logic [CW-1:0]  w_cnt_init;

    assign ex_busy       = (r_state != S_IDLE);
    assign ex_done       = r_done;
    assign ex_carry      = r_carry;
    assign ex_zero       = r_zero;
    assign rf_write_addr = r_waddr;
    assign rf_write_en   = r_wen;
    assign rf_write_val  = r_wval;
    assign rf_reset_acc  = r_rst_acc;

    // EXEC length chosen at accept: SHL by B[2:0] (at least one cycle), MUL fixed.
    always_comb begin
        w_cnt_init = CW'(1);
        if (ex_op == OP_SHL) begin
            if (ex_read_i[2:0] != 3'd0) begin
                w_cnt_init = CW'(ex_read_i[2:0]);
            end
        end else if (ex_op == OP_MUL) begin
            w_cnt_init = CW'(MUL_ITERS);
        end
    end

    // Result/carry of the current EXEC cycle; for SHL/MUL this is one iteration step.
    always_comb begin
        w_sum        = {1'b0, r_a} + {1'b0, r_b};
        w_diff       = {1'b0, r_a} - {1'b0, r_b};
        w_prod_next  = r_prod + (r_mplier[0] ? r_mcand : 16'd0);
        w_shl_active = (r_b[2:0] != 3'd0);
        w_result     = 8'd0;
        w_carry      = r_carry;
        case (r_op)
            OP_ADD: begin
                w_result = w_sum[7:0];
                w_carry  = w_sum[8];
            end
            OP_SUB: begin
                w_result = w_diff[7:0];
                w_carry  = w_diff[8];
            end
            OP_AND: w_result = r_a & r_b;
            OP_OR:  w_result = r_a | r_b;
            OP_XOR: w_result = r_a ^ r_b;
            OP_SHL: begin
                if (w_shl_active) begin
                    w_result = {r_a[6:0], 1'b0};
                    w_carry  = r_a[7];
                end else begin
                    w_result = r_a;
                end
            end
            OP_MUL: begin
                w_result = w_prod_next[7:0];
                w_carry  = (w_prod_next[15:8] != 8'd0);
            end
            default: begin
                w_result = 8'd0;
                w_carry  = 1'b0;
            end
        endcase
    end

    // Control FSM, operand latches, iteration state and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_dst     <= '0;
            r_a       <= 8'd0;
            r_b       <= 8'd0;
            r_cnt     <= '0;
            r_prod    <= 16'd0;
            r_mcand   <= 16'd0;
            r_mplier  <= 8'd0;
            r_done    <= 1'b0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_waddr   <= '0;
            r_wen     <= 1'b0;
            r_wval    <= 8'd0;
            r_rst_acc <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ex_start) begin
                        r_op     <= ex_op;
                        r_dst    <= ex_dst;
                        r_a      <= ex_acc_i;
                        r_b      <= ex_read_i;
                        r_cnt    <= w_cnt_init;
                        r_prod   <= 16'd0;
                        r_mcand  <= {8'd0, ex_acc_i};
                        r_mplier <= ex_read_i;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt <= CW'(1)) begin
                        r_state   <= S_WB;
                        r_done    <= 1'b1;
                        r_carry   <= w_carry;
                        r_zero    <= (w_result == 8'd0);
                        r_wval    <= w_result;
                        r_wen     <= (r_op != OP_CLR);
                        r_rst_acc <= (r_op == OP_CLR);
                        r_waddr   <= (r_op == OP_CLR) ? '0 : r_dst;
                    end else begin
                        r_cnt    <= r_cnt - CW'(1);
                        r_a      <= w_result;
                        r_prod   <= w_prod_next;
                        r_mcand  <= {r_mcand[14:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[7:1]};
                    end
                end
                S_WB: begin
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_wen     <= 1'b0;
                    r_rst_acc <= 1'b0;
                    r_waddr   <= '0;
                    r_wval    <= 8'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: each issued op pushes its expected
// write-back (including the cycle it must appear in); a monitor pops and
// compares whenever the DUT presents a write-back.
module tb_alu_exec_unit;

    logic       clk;
    logic       reset;
    logic       ex_start;
    logic [2:0] ex_op;
    logic [2:0] ex_dst;
    logic [7:0] ex_acc_i;
    logic [7:0] ex_read_i;
    logic       ex_busy;
    logic       ex_done;
    logic       ex_carry;
    logic       ex_zero;
    logic [2:0] rf_write_addr;
    logic       rf_write_en;
    logic [7:0] rf_write_val;
    logic       rf_reset_acc;

    alu_exec_unit #(.RAW(3), .MUL_ITERS(8)) dut (
        .clk(clk), .reset(reset), .ex_start(ex_start), .ex_op(ex_op),
        .ex_dst(ex_dst), .ex_acc_i(ex_acc_i), .ex_read_i(ex_read_i),
        .ex_busy(ex_busy), .ex_done(ex_done), .ex_carry(ex_carry),
        .ex_zero(ex_zero), .rf_write_addr(rf_write_addr),
        .rf_write_en(rf_write_en), .rf_write_val(rf_write_val),
        .rf_reset_acc(rf_reset_acc)
    );

    typedef struct {
        logic [2:0] addr;
        logic [7:0] val;
        logic       we;
        logic       ra;
        logic       c;
        logic       z;
        logic       chk_addr;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every write-back against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ex_done === 1'b1 || rf_write_en === 1'b1 || rf_reset_acc === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wb: done=%b we=%b ra=%b with nothing outstanding (cycle %0d)",
                         ex_done, rf_write_en, rf_reset_acc, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_cycle", cyc, e.cyc);
                chk("wb_done", {31'd0, ex_done}, 32'd1);
                chk("wb_busy", {31'd0, ex_busy}, 32'd1);
                chk("wb_we", {31'd0, rf_write_en}, {31'd0, e.we});
                chk("wb_reset_acc", {31'd0, rf_reset_acc}, {31'd0, e.ra});
                if (e.chk_addr) chk("wb_addr", {29'd0, rf_write_addr}, {29'd0, e.addr});
                chk("wb_val", {24'd0, rf_write_val}, {24'd0, e.val});
                chk("wb_carry", {31'd0, ex_carry}, {31'd0, e.c});
                chk("wb_zero", {31'd0, ex_zero}, {31'd0, e.z});
            end
        end else if (reset === 1'b0) begin
            chk("idle_addr_val", {21'd0, rf_write_addr, rf_write_val}, 32'd0);
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [2:0] dst,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_val, input logic exp_c,
                          input logic exp_z, input int len);
        exp_t e;
        int   n;
        @(negedge clk);
        ex_op     = op;
        ex_dst    = dst;
        ex_acc_i  = a;
        ex_read_i = b;
        ex_start  = 1'b1;
        e.addr     = dst;
        e.val      = exp_val;
        e.we       = (op != 3'b111);
        e.ra       = (op == 3'b111);
        e.c        = exp_c;
        e.z        = exp_z;
        e.chk_addr = (op != 3'b111);
        e.cyc      = cyc + 1 + len;
        q.push_back(e);
        @(negedge clk);
        ex_start = 1'b0;
        n = 0;
        while (ex_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("busy_drop_cycle", cyc, e.cyc + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ex_start  = 1'b0;
        ex_op     = 3'd0;
        ex_dst    = 3'd0;
        ex_acc_i  = 8'd0;
        ex_read_i = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {16'd0, ex_busy, ex_done, ex_carry, ex_zero, rf_write_addr,
             rf_write_en, rf_write_val, rf_reset_acc}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //      op      dst   A      B      val    c     z     len
        run_op(3'b000, 3'd2, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1); // ADD with carry out
        run_op(3'b010, 3'd3, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0, 1); // AND keeps carry
        run_op(3'b011, 3'd4, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1); // OR zero result
        run_op(3'b100, 3'd6, 8'hAA, 8'h55, 8'hFF, 1'b1, 1'b0, 1); // XOR
        run_op(3'b001, 3'd0, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1); // SUB borrow
        run_op(3'b001, 3'd1, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1); // SUB equal
        run_op(3'b101, 3'd2, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3); // SHL by 3
        run_op(3'b101, 3'd2, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1); // SHL by 1
        run_op(3'b101, 3'd7, 8'h81, 8'hF8, 8'h81, 1'b1, 1'b0, 1); // SHL by 0, B[7:3] ignored
        run_op(3'b110, 3'd3, 8'h13, 8'h0B, 8'hD1, 1'b0, 1'b0, 8); // MUL
        run_op(3'b111, 3'd5, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1); // CLR

        // MUL with ex_start held and operands changing during EXEC/WB.
        begin
            exp_t e;
            @(negedge clk);
            ex_op     = 3'b110;
            ex_dst    = 3'd3;
            ex_acc_i  = 8'h13;
            ex_read_i = 8'h0B;
            ex_start  = 1'b1;
            e.addr = 3'd3; e.val = 8'hD1; e.we = 1'b1; e.ra = 1'b0;
            e.c = 1'b0; e.z = 1'b0; e.chk_addr = 1'b1; e.cyc = cyc + 9;
            q.push_back(e);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ex_done) begin
                    ex_start = 1'b0;
                    break;
                end
                ex_start  = 1'b1;
                ex_op     = 3'b000;
                ex_dst    = 3'd7;
                ex_acc_i  = 8'h55 + 8'(i);
                ex_read_i = 8'hAA;
            end
            ex_start = 1'b0;
            @(negedge clk);
            chk("busy_after_spam", {31'd0, ex_busy}, 32'd0);
            repeat (3) @(negedge clk);
        end

        run_op(3'b110, 3'd4, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1, 8); // MUL overflow

        // Reset in the middle of a MUL: no write-back, flags cleared.
        @(negedge clk);
        ex_op     = 3'b110;
        ex_dst    = 3'd1;
        ex_acc_i  = 8'h13;
        ex_read_i = 8'h0B;
        ex_start  = 1'b1;
        @(negedge clk);
        ex_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, ex_busy}, 32'd0);
        chk("abort_flags", {30'd0, ex_carry, ex_zero}, 32'd0);
        chk("abort_done", {31'd0, ex_done}, 32'd0);
        repeat (12) @(negedge clk);

        // Reset and start together: reset wins.
        ex_op     = 3'b000;
        ex_acc_i  = 8'h01;
        ex_read_i = 8'h01;
        reset     = 1'b1;
        ex_start  = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        ex_start = 1'b0;
        chk("reset_vs_start_busy", {31'd0, ex_busy}, 32'd0);
        repeat (5) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle execute stage directly downstream of the 8-bit accumulator register file. Consumes the file's accumulator and addressed-read outputs and produces its write-back controls (write address, write enable, write value, accumulator reset). Single-cycle logic/arith ops plus iterative shift and multiply under a start/busy/done handshake to the control unit.

Parameters:
RAW, 3, register address width (matches register file; 2**RAW registers)
MUL_ITERS, 8, shift-add iterations for MUL (equals data width)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
ex_start  in  1  request to begin op; accepted only in IDLE
ex_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 CLR
ex_dst  in  RAW  destination register address
ex_acc_i  in  8  operand A (from register file accumulator output)
ex_read_i  in  8  operand B (from register file read output)
ex_busy  out  1  high in EXEC and WB
ex_done  out  1  one-cycle pulse in WB
ex_carry  out  1  carry/borrow flag
ex_zero  out  1  zero flag
rf_write_addr  out  RAW  to register file
rf_write_en  out  1  to register file
rf_write_val  out  8  to register file
rf_reset_acc  out  1  to register file

Behaviour:
- Single clock; reset synchronous, active-high. Reset: state IDLE, all outputs 0, internal regs 0.
- States: IDLE, EXEC, WB. IDLE & ex_start -> EXEC (cycle T accept, op/dst/A/B latched at the T edge). EXEC -> WB when iteration count is exhausted. WB -> IDLE unconditionally.
- Operands latched at accept; later changes on ex_acc_i/ex_read_i/ex_op/ex_dst have no effect.
- ex_start ignored while busy (EXEC or WB). Earliest next accept: first IDLE cycle after WB.
- EXEC length: ADD/SUB/AND/OR/XOR/CLR 1 cycle. SHL max(B[2:0],1) cycles. MUL MUL_ITERS cycles.
- WB occurs at T+1+EXEC length (single-cycle ops: T+2; MUL: T+9). Outputs registered; in WB only: ex_done=1, rf_write_en=1 (except CLR), rf_write_addr=dst, rf_write_val=result. Outside WB, rf_write_en, rf_reset_acc and ex_done are 0; rf_write_addr/val hold 0.
- ADD: result=(A+B)[7:0]; carry=bit 8.
- SUB: result=(A-B)[7:0]; carry=1 iff A<B (borrow).
- AND/OR/XOR: bitwise; carry unchanged.
- SHL: left shift A one bit per EXEC cycle, B[2:0] times; carry=last bit shifted out. B[2:0]=0: one idle EXEC cycle, result=A, carry unchanged. B[7:3] ignored.
- MUL: shift-add, unsigned; result=low byte of A*B; carry=1 iff high byte nonzero.
- CLR: WB drives rf_reset_acc=1, rf_write_en=0; ex_dst ignored; zero=1, carry=0.
- ex_zero updated in WB to (result==0) for all ops; flags otherwise hold.
- Reset mid-operation (any state): next edge IDLE, no write-back issued, flags cleared, done not pulsed.
- Reset and ex_start in same cycle: reset wins, op not accepted.

Test Plan:
1. Reset, then ADD A=0xF0 B=0x20 dst=2 accepted at T -> T+2: rf_write_en=1, addr=2, val=0x10, carry=1, zero=0, done=1; T+3 busy=0.
2. SUB A=0x05 B=0x07 dst=0 -> val=0xFE, carry=1; then SUB A=0x07 B=0x07 -> val=0x00, carry=0, zero=1.
3. SHL A=0x81 B=0x03 -> WB at T+4, val=0x08, carry=0; SHL A=0x81 B=0x01 -> WB T+2, val=0x02, carry=1; SHL B=0x00 -> WB T+2, val=A, carry unchanged.
4. MUL A=0x13 B=0x0B -> WB at T+9, val=0xD1, carry=0; MUL A=0x20 B=0x10 -> val=0x00, carry=1, zero=1.
5. CLR dst=5 -> T+2: rf_reset_acc=1, rf_write_en=0, zero=1. ex_start pulsed during EXEC/WB of a MUL and ex_acc_i changed after accept -> ignored, MUL result unchanged.
6. MUL accepted at T, reset at T+4 -> T+5: IDLE, busy=0, flags 0, no rf_write_en or done in any later cycle.
